// File: rtl/fib_seq.sv
// Fibonacci program sequencer: walks a fixed instruction program that leaves F(n) in R0
// and emits one opcode/operand pair per cycle to an external datapath.
module fib_seq #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] n,
    input  logic            en,
    output logic [2:0]      op_code,
    output logic [1:0]      Opr1,
    output logic [1:0]      Opr2,
    output logic            busy,
    output logic            done
);

    localparam logic [2:0] OP_NOOP  = 3'b000;
    localparam logic [2:0] OP_SET   = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_ADD   = 3'b110;
    localparam logic [2:0] OP_COPY  = 3'b111;

    localparam logic [1:0] R_A    = 2'd0;
    localparam logic [1:0] R_B    = 2'd1;
    localparam logic [1:0] R_TEMP = 2'd2;

    localparam logic [SIZE-1:0] CNT_ONE = SIZE'(1);

    typedef enum logic [3:0] {
        IDLE, INIT0, INIT1, INIT2, L_COPY, L_ADD, L_MOV, STORE, DONE
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] opr1;
        logic [1:0] opr2;
        logic       busy;
        logic       done;
    } ctl_t;

    state_t          state;
    state_t          nxt;
    logic [SIZE-1:0] cnt;
    ctl_t            ctl;

    // Control word for a state; fields not used by that state stay zero.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            INIT0:   begin c.op = OP_SET;   c.opr1 = R_A; end
            INIT1:   begin c.op = OP_SET;   c.opr1 = R_B; end
            INIT2:   begin c.op = OP_INC;   c.opr1 = R_B; end
            L_COPY:  begin c.op = OP_COPY;  c.opr1 = R_TEMP; c.opr2 = R_B;    end
            L_ADD:   begin c.op = OP_ADD;   c.opr1 = R_B;    c.opr2 = R_A;    end
            L_MOV:   begin c.op = OP_COPY;  c.opr1 = R_A;    c.opr2 = R_TEMP; end
            STORE:   begin c.op = OP_STORE; c.opr1 = R_A; end
            DONE:    c.op = OP_NOOP;
            default: c.op = OP_NOOP;
        endcase
        c.busy = (s != IDLE);
        c.done = (s == DONE);
        return c;
    endfunction

    // NOTE: nxt is assigned before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        nxt = state;
        if (state == IDLE) begin
            if (start) nxt = INIT0;
        end else if (en) begin
            case (state)
                INIT0:   nxt = INIT1;
                INIT1:   nxt = INIT2;
                INIT2:   nxt = (cnt != '0) ? L_COPY : STORE;
                L_COPY:  nxt = L_ADD;
                L_ADD:   nxt = L_MOV;
                L_MOV:   nxt = (cnt == CNT_ONE) ? STORE : L_COPY;
                STORE:   nxt = DONE;
                default: nxt = IDLE;
            endcase
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ctl   <= '0;
        end else begin
            state <= nxt;
            ctl   <= decode(nxt);
            if (state == IDLE && start)
                cnt <= n;
            else if (state == L_MOV && en)
                cnt <= cnt - CNT_ONE;
        end
    end

    // A stalled cycle must issue a noop to the datapath; busy reflects the held state.
    assign op_code = en ? ctl.op   : OP_NOOP;
    assign Opr1    = en ? ctl.opr1 : 2'd0;
    assign Opr2    = en ? ctl.opr2 : 2'd0;
    assign done    = en & ctl.done;
    assign busy    = ctl.busy;

endmodule
